prog_mem: RTL

//  Writable, parametrised instruction memory replacing the fixed mux-based ROM.
//  A handshaked load port fills the program; the fetch port returns RES_INS for PC with 1-cycle latency.

---
 rtl/prog_mem_pkg.sv | 18 +
 rtl/prog_mem_array.sv | 23 ++
 rtl/prog_mem.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the writable program memory.
// Build option: PROG_MEM_PARITY_EN adds an even-parity bit per entry.
package prog_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL,
    RUN
  } state_t;

  localparam logic [8:0] NOOP_9B = 9'b011000000;

  function automatic logic even_par(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Program storage: synchronous write port, registered read port.
// Contents are deliberately left uninitialised by reset.
module prog_mem_array #(
  parameter int W      = 9,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [1<<ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/prog_mem.sv
// Loadable instruction memory: load FSM with NOOP tail fill and fetch port.
// Build option: PROG_MEM_PARITY_EN stores and checks an even-parity bit.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int               INS_W  = 9,
  parameter int               ADDR_W = 4,
  parameter logic [INS_W-1:0] NOOP   = INS_W'(NOOP_9B)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic              LD_LAST,
  input  logic [INS_W-1:0]  LD_DATA,
  output logic              LD_READY,
  output logic              LD_DONE,
  input  logic [ADDR_W-1:0] PC,
  input  logic              FETCH_EN,
  output logic [INS_W-1:0]  RES_INS,
  output logic              INS_VALID,
  output logic              BUSY,
  output logic              PAR_ERR
);

`ifdef PROG_MEM_PARITY_EN
  localparam int AW = INS_W + 1;
`else
  localparam int AW = INS_W;
`endif

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_ptr, ptr_nx;
  logic              loaded, loaded_nx;
  logic              show_mem;
  logic              ins_valid;
  logic              we;
  logic [INS_W-1:0]  wdata;
  logic [AW-1:0]     arr_wdata;
  logic [AW-1:0]     rdata;
  logic              fetch;
  logic              last_slot;

  assign last_slot = (wr_ptr == {ADDR_W{1'b1}});

  always_comb begin
    state_nx  = state;
    ptr_nx    = wr_ptr;
    loaded_nx = loaded;
    we        = 1'b0;
    wdata     = NOOP;
    LD_DONE   = 1'b0;
    unique case (state)
      IDLE: begin
        if (LD_START) begin
          state_nx  = LOAD;
          ptr_nx    = '0;
          loaded_nx = 1'b0;
        end
      end
      LOAD: begin
        if (LD_START) begin
          ptr_nx = '0;
        end else if (LD_VALID) begin
          we     = 1'b1;
          wdata  = LD_DATA;
          ptr_nx = wr_ptr + 1'b1;
          if (last_slot) begin
            state_nx  = RUN;
            LD_DONE   = 1'b1;
            loaded_nx = 1'b1;
          end else if (LD_LAST) begin
            state_nx = FILL;
          end
        end
      end
      FILL: begin
        if (LD_START) begin
          state_nx = LOAD;
          ptr_nx   = '0;
        end else begin
          we     = 1'b1;
          ptr_nx = wr_ptr + 1'b1;
          if (last_slot) begin
            state_nx  = RUN;
            LD_DONE   = 1'b1;
            loaded_nx = 1'b1;
          end
        end
      end
      RUN: begin
        if (LD_START) begin
          state_nx  = LOAD;
          ptr_nx    = '0;
          loaded_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // a load request always beats a same-cycle fetch
  assign fetch = (state == RUN) && loaded && FETCH_EN && !LD_START;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      loaded    <= 1'b0;
      show_mem  <= 1'b0;
      ins_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_ptr    <= ptr_nx;
      loaded    <= loaded_nx;
      ins_valid <= fetch;
      if (fetch)
        show_mem <= 1'b1;
      else if (state != RUN || LD_START)
        show_mem <= 1'b0;
    end
  end

`ifdef PROG_MEM_PARITY_EN
  assign arr_wdata = {even_par(32'(wdata)), wdata};
  assign PAR_ERR   = ins_valid && (^rdata);
`else
  assign arr_wdata = wdata;
  assign PAR_ERR   = 1'b0;
`endif

  prog_mem_array #(
    .W      (AW),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (CLK),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (arr_wdata),
    .re    (fetch),
    .raddr (PC),
    .rdata (rdata)
  );

  assign RES_INS   = show_mem ? rdata[INS_W-1:0] : NOOP;
  assign INS_VALID = ins_valid;
  assign LD_READY  = (state == LOAD);
  assign BUSY      = (state == LOAD) || (state == FILL);

endmodule
